camera_stream_emulator: RTL and testbench

- Synthetic camera source: the transmit end of the parallel camera pixel bus (vsync/href/8-bit data, RGB565, two bytes per pixel) that the frame-capture logic receives.
- Drives camera_capture and the frame buffer in simulation and on-board, in place of the physical camera, with known test patterns including coloured blobs for image_hunt checks.
- Runs on the pixel clock domain; one byte per clk cycle.

---
 rtl/camera_emu_pkg.sv | 67 ++++++
 rtl/camera_stream_emulator_if.sv | 11 +
 rtl/camera_pattern_pixel.sv | 45 ++++
 rtl/camera_stream_emulator.sv | 146 ++++++++++++++
 tb/tb_camera_stream_emulator.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_emu_pkg.sv
// Shared types and constants for the synthetic RGB565 camera source.
// Pattern encodings, colour constants, FSM states and the per-frame config bundle.
package camera_emu_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_SOLID = 2'd1,
        PAT_BLOBS = 2'd2,
        PAT_RAMP  = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } state_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    localparam logic [15:0] BLOB_RED    = 16'hF800;
    localparam logic [15:0] BLOB_GREEN  = 16'h07E0;
    localparam logic [15:0] BLOB_BLUE   = 16'h001F;
    localparam logic [15:0] BACKGROUND  = 16'h0000;

    typedef struct packed {
        pattern_e    pattern;
        logic [15:0] solid;
        logic [9:0]  red_x;
        logic [9:0]  red_y;
        logic [9:0]  green_x;
        logic [9:0]  green_y;
        logic [9:0]  blue_x;
        logic [9:0]  blue_y;
    } frame_cfg_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    // 11-bit compare so a blob anchored near 1023 cannot wrap past zero
    function automatic logic in_blob(input logic [10:0] x, input logic [10:0] y,
                                     input logic [9:0] bx, input logic [9:0] by,
                                     input logic [10:0] size);
        return (x >= {1'b0, bx}) && (x < ({1'b0, bx} + size)) &&
               (y >= {1'b0, by}) && (y < ({1'b0, by} + size));
    endfunction

endpackage

// File: rtl/camera_stream_emulator_if.sv
// Parallel camera pixel bus as driven by the emulator, plus frame status.
interface camera_stream_emulator_if;
    logic        camera_vsync;
    logic        camera_href;
    logic [7:0]  camera_data;
    logic        frame_done;
    logic [15:0] frame_count;

    modport master (output camera_vsync, camera_href, camera_data, frame_done, frame_count);
    modport slave  (input  camera_vsync, camera_href, camera_data, frame_done, frame_count);
endinterface

// File: rtl/camera_pattern_pixel.sv
// Registered RGB565 pattern generator: rgb565 reflects (x, y, cfg) one cycle later.
module camera_pattern_pixel
    import camera_emu_pkg::*;
#(
    parameter int H_PIXELS  = 640,
    parameter int BLOB_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  frame_cfg_t  cfg,
    output logic [15:0] rgb565
);

    localparam logic [10:0] BAR_W = 11'((H_PIXELS / 8 > 0) ? H_PIXELS / 8 : 1);
    localparam logic [10:0] BLOB  = 11'(BLOB_SIZE);

    logic [15:0] rgb_d;

    always_comb begin
        rgb_d = BACKGROUND;
        case (cfg.pattern)
            PAT_BARS:  rgb_d = bar_color(3'(x / BAR_W));
            PAT_SOLID: rgb_d = cfg.solid;
            PAT_BLOBS: begin
                // red wins over green wins over blue where blobs overlap
                if (in_blob(x, y, cfg.red_x, cfg.red_y, BLOB))
                    rgb_d = BLOB_RED;
                else if (in_blob(x, y, cfg.green_x, cfg.green_y, BLOB))
                    rgb_d = BLOB_GREEN;
                else if (in_blob(x, y, cfg.blue_x, cfg.blue_y, BLOB))
                    rgb_d = BLOB_BLUE;
            end
            PAT_RAMP:  rgb_d = {y[7:0], x[7:0]};
            default:   rgb_d = BACKGROUND;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rgb565 <= '0;
        else        rgb565 <= rgb_d;
    end

endmodule

// File: rtl/camera_stream_emulator.sv
// Synthetic camera source: emits vsync/href/8-bit RGB565 frames from latched test patterns.
module camera_stream_emulator
    import camera_emu_pkg::*;
#(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int BLOB_SIZE   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb565,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  green_x,
    input  logic [9:0]  green_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    camera_stream_emulator_if.master cam
);

    localparam int LINE_TOTAL = 2 * H_PIXELS + H_BLANK;
    localparam int CW         = $clog2(LINE_TOTAL);

    localparam logic [CW-1:0] COL_LAST  = CW'(LINE_TOTAL - 1);
    localparam logic [CW-1:0] HREF_LAST = CW'(2 * H_PIXELS - 1);
    localparam logic [10:0]   VS_LAST   = 11'(VSYNC_LINES - 1);
    localparam logic [10:0]   VB_LAST   = 11'(V_BACK - 1);
    localparam logic [10:0]   VL_LAST   = 11'(V_LINES - 1);
    localparam logic [10:0]   VF_LAST   = 11'(V_FRONT - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [10:0] line_q, line_d;
    frame_cfg_t  cfg_q, cfg_d, cfg_in;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        done;
    logic        col_wrap;
    logic [10:0] x_issue, y_issue;
    logic [15:0] rgb;

    assign cfg_in = '{pattern: pattern_e'(pattern_sel), solid: solid_rgb565,
                      red_x: red_x, red_y: red_y, green_x: green_x,
                      green_y: green_y, blue_x: blue_x, blue_y: blue_y};

    assign col_wrap = (col_q == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            cfg_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            cfg_q       <= cfg_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_wrap ? '0 : col_q + 1'b1;
        line_d      = line_q;
        cfg_d       = cfg_q;
        frame_cnt_d = frame_cnt_q;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                col_d  = '0;
                line_d = '0;
                if (enable) begin
                    state_d = ST_VSYNC;
                    cfg_d   = cfg_in;
                end
            end
            ST_VSYNC: if (col_wrap) begin
                line_d = (line_q == VS_LAST) ? '0 : line_q + 11'd1;
                if (line_q == VS_LAST) state_d = ST_VBACK;
            end
            ST_VBACK: if (col_wrap) begin
                line_d = (line_q == VB_LAST) ? '0 : line_q + 11'd1;
                if (line_q == VB_LAST) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: if (col_q == HREF_LAST) state_d = ST_HBLANK;
            ST_HBLANK: if (col_wrap) begin
                line_d  = (line_q == VL_LAST) ? '0 : line_q + 11'd1;
                state_d = (line_q == VL_LAST) ? ST_VFRONT : ST_ACTIVE;
            end
            ST_VFRONT: if (col_wrap) begin
                if (line_q == VF_LAST) begin
                    done        = 1'b1;
                    line_d      = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (enable) begin
                        state_d = ST_VSYNC;
                        cfg_d   = cfg_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    line_d = line_q + 11'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Coordinates for the next cycle's column so the registered pixel lands on time
    assign x_issue = col_wrap ? '0 : 11'((int'(col_q) + 1) / 2);

    always_comb begin
        y_issue = '0;
        if (state_q == ST_HBLANK && col_wrap)
            y_issue = line_q + 11'd1;
        else if (state_q == ST_ACTIVE || state_q == ST_HBLANK)
            y_issue = line_q;
    end

    camera_pattern_pixel #(
        .H_PIXELS  (H_PIXELS),
        .BLOB_SIZE (BLOB_SIZE)
    ) u_pixel (
        .clk    (clk),
        .reset  (reset),
        .x      (x_issue),
        .y      (y_issue),
        .cfg    (cfg_q),
        .rgb565 (rgb)
    );

    assign cam.camera_vsync = (state_q == ST_VSYNC);
    assign cam.camera_href  = (state_q == ST_ACTIVE);
    assign cam.camera_data  = (state_q == ST_ACTIVE) ? (col_q[0] ? rgb[7:0] : rgb[15:8]) : 8'h00;
    assign cam.frame_done   = done;
    assign cam.frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_camera_stream_emulator.sv
// Bench for camera_stream_emulator: table-driven pixel vectors, random frames against a flat frame model.
module tb_camera_stream_emulator;
    localparam int HP = 8, VL = 4, HB = 4, VS = 1, VB = 2, VF = 1, BS = 2;
    localparam int LT = 2 * HP + HB;
    localparam int FRAME = (VS + VB + VL + VF) * LT;
    localparam int CAP = 2 * FRAME;

    logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic [1:0]  pattern_sel = '0;
    logic [15:0] solid_rgb565 = '0;
    logic [9:0]  red_x = '0, red_y = '0, green_x = '0, green_y = '0, blue_x = '0, blue_y = '0;

    camera_stream_emulator_if cam();

    camera_stream_emulator #(
        .H_PIXELS(HP), .V_LINES(VL), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK(VB), .V_FRONT(VF), .BLOB_SIZE(BS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb565(solid_rgb565), .red_x(red_x), .red_y(red_y),
        .green_x(green_x), .green_y(green_y), .blue_x(blue_x), .blue_y(blue_y),
        .cam(cam)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pat;
        logic [15:0] solid;
        logic [9:0]  rx, ry, gx, gy, bx, by;
    } tcfg_t;

    typedef struct {
        tcfg_t       cfg;
        int          y;
        int          x;
        logic [15:0] exp;
    } vec_t;

    int checks = 0, passes = 0;
    logic [15:0] exp_cnt = '0;
    logic        cap_vs[CAP], cap_hr[CAP], cap_dn[CAP];
    logic [7:0]  cap_d[CAP];
    vec_t        vecs[$];

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic tcfg_t mkcfg(input logic [1:0] pat, input logic [15:0] solid,
                                    input int rx, input int ry, input int gx, input int gy,
                                    input int bx, input int by);
        tcfg_t c;
        c.pat = pat; c.solid = solid;
        c.rx = 10'(rx); c.ry = 10'(ry); c.gx = 10'(gx); c.gy = 10'(gy); c.bx = 10'(bx); c.by = 10'(by);
        return c;
    endfunction

    function automatic logic [9:0] rand_coord();
        return ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 9));
    endfunction

    function automatic tcfg_t rand_cfg();
        tcfg_t c;
        c.pat = 2'($urandom_range(0, 3)); c.solid = 16'($urandom);
        c.rx = rand_coord(); c.ry = rand_coord(); c.gx = rand_coord();
        c.gy = rand_coord(); c.bx = rand_coord(); c.by = rand_coord();
        return c;
    endfunction

    function automatic bit inside_sq(input int x, input int y, input int bx, input int by);
        return (x >= bx) && (x < bx + BS) && (y >= by) && (y < by + BS);
    endfunction

    // Reference pixel straight from the pattern rules
    function automatic logic [15:0] ref_pixel(input tcfg_t c, input int x, input int y);
        logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (c.pat)
            2'd0: return bars[(x * 8 / HP) % 8];
            2'd1: return c.solid;
            2'd2: begin
                if (inside_sq(x, y, int'(c.rx), int'(c.ry))) return 16'hF800;
                if (inside_sq(x, y, int'(c.gx), int'(c.gy))) return 16'h07E0;
                if (inside_sq(x, y, int'(c.bx), int'(c.by))) return 16'h001F;
                return 16'h0000;
            end
            default: return 16'(((y % 256) << 8) | (x % 256));
        endcase
    endfunction

    task automatic apply_cfg(input tcfg_t c);
        pattern_sel = c.pat; solid_rgb565 = c.solid;
        red_x = c.rx; red_y = c.ry; green_x = c.gx; green_y = c.gy; blue_x = c.bx; blue_y = c.by;
    endtask

    task automatic capture(input int n, input int drop_at, input bit scramble);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_vs[k] = cam.camera_vsync; cap_hr[k] = cam.camera_href;
            cap_d[k]  = cam.camera_data;  cap_dn[k] = cam.frame_done;
            if (k == drop_at) enable = 1'b0;
            if (scramble) apply_cfg(rand_cfg());
        end
    endtask

    // Starts from IDLE; capture index 0 is the first vsync cycle
    task automatic run_frame(input tcfg_t c, input int n, input int drop_at, input bit scramble);
        @(negedge clk);
        apply_cfg(c);
        enable = 1'b1;
        capture(n, drop_at, scramble);
    endtask

    task automatic compare_frame(input string name, input int base, input tcfg_t c);
        int bad = 0;
        string first = "";
        for (int k = 0; k < FRAME; k++) begin
            int L = k / LT, col = k % LT;
            logic evs, ehr, edn;
            logic [15:0] pix;
            logic [7:0] ed;
            evs = (L < VS);
            ehr = (L >= VS + VB) && (L < VS + VB + VL) && (col < 2 * HP);
            pix = ref_pixel(c, col / 2, L - VS - VB);
            ed  = ehr ? ((col % 2) ? pix[7:0] : pix[15:8]) : 8'h00;
            edn = (k == FRAME - 1);
            if (cap_vs[base+k] !== evs || cap_hr[base+k] !== ehr ||
                cap_d[base+k] !== ed || cap_dn[base+k] !== edn) begin
                if (bad == 0)
                    first = $sformatf("cycle %0d got vs/href/data/done %b/%b/%h/%b want %b/%b/%h/%b",
                                      k, cap_vs[base+k], cap_hr[base+k], cap_d[base+k], cap_dn[base+k],
                                      evs, ehr, ed, edn);
                bad++;
            end
        end
        check(name, bad == 0, $sformatf("%0d bad cycles, first %s", bad, first));
    endtask

    task automatic expect_idle(input string name, input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (cam.camera_vsync || cam.camera_href || cam.camera_data != 8'h00 || cam.frame_done) bad++;
        end
        check(name, bad == 0, $sformatf("%0d of %0d idle cycles active, want 0", bad, n));
    endtask

    task automatic check_count(input string name);
        @(negedge clk);
        check(name, cam.frame_count === exp_cnt,
              $sformatf("frame_count %h want %h", cam.frame_count, exp_cnt));
    endtask

    initial begin
        tcfg_t c;
        tcfg_t blob = mkcfg(2, 0, 1, 1, 2, 1, 6, 3);

        // Pixel vectors: {config, y, x, expected RGB565}
        vecs.push_back('{mkcfg(1, 16'hA5C3, 0, 0, 0, 0, 0, 0), 0, 0, 16'hA5C3});
        vecs.push_back('{mkcfg(1, 16'h1234, 0, 0, 0, 0, 0, 0), 3, 7, 16'h1234});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 16'hFFFF});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 16'hFFE0});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 2, 2, 16'h07FF});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 3, 3, 16'h07E0});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 0, 4, 16'hF81F});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 1, 5, 16'hF800});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 2, 6, 16'h001F});
        vecs.push_back('{mkcfg(0, 0, 0, 0, 0, 0, 0, 0), 3, 7, 16'h0000});
        vecs.push_back('{blob, 1, 1, 16'hF800});
        vecs.push_back('{blob, 1, 2, 16'hF800});
        vecs.push_back('{blob, 1, 3, 16'h07E0});
        vecs.push_back('{blob, 3, 6, 16'h001F});
        vecs.push_back('{blob, 3, 7, 16'h001F});
        vecs.push_back('{blob, 0, 1, 16'h0000});
        vecs.push_back('{blob, 3, 5, 16'h0000});
        vecs.push_back('{mkcfg(3, 0, 0, 0, 0, 0, 0, 0), 2, 5, 16'h0205});
        vecs.push_back('{mkcfg(3, 0, 0, 0, 0, 0, 0, 0), 3, 7, 16'h0307});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset vsync", cam.camera_vsync === 1'b0, $sformatf("got %b want 0", cam.camera_vsync));
        check("reset href", cam.camera_href === 1'b0, $sformatf("got %b want 0", cam.camera_href));
        check("reset data", cam.camera_data === 8'h00, $sformatf("got %h want 00", cam.camera_data));
        check("reset done", cam.frame_done === 1'b0, $sformatf("got %b want 0", cam.frame_done));
        check("reset count", cam.frame_count === 16'h0, $sformatf("got %h want 0000", cam.frame_count));
        reset = 1'b1;
        expect_idle("idle before enable", 5);

        // First frame, solid A5C3: timing structure
        c = mkcfg(1, 16'hA5C3, 0, 0, 0, 0, 0, 0);
        run_frame(c, FRAME, 0, 1'b0);
        compare_frame("solid frame", 0, c);
        begin
            int vs_n = 0, pulses = 0, bad_len = 0, bad_gap = 0, rise = 0, fall = -1, bad_byte = 0, dn_n = 0;
            for (int k = 0; k < FRAME; k++) begin
                vs_n += int'(cap_vs[k]);
                dn_n += int'(cap_dn[k]);
                if (cap_hr[k] && (k == 0 || !cap_hr[k-1])) begin
                    rise = k;
                    if (fall >= 0 && k - fall != HB) bad_gap++;
                end
                if (!cap_hr[k] && k > 0 && cap_hr[k-1]) begin
                    pulses++; fall = k;
                    if (k - rise != 2 * HP) bad_len++;
                end
                if (cap_hr[k] && cap_d[k] !== (((k % LT) % 2) ? 8'hC3 : 8'hA5)) bad_byte++;
            end
            check("vsync width", vs_n == LT && cap_vs[0] && !cap_vs[LT],
                  $sformatf("vsync high %0d cycles want %0d", vs_n, LT));
            check("href pulses", pulses == VL && bad_len == 0 && bad_gap == 0,
                  $sformatf("%0d pulses, %0d bad lengths, %0d bad gaps; want %0d/0/0", pulses, bad_len, bad_gap, VL));
            check("byte alternation", bad_byte == 0, $sformatf("%0d bytes off A5/C3, want 0", bad_byte));
            check("frame_done at 160", cap_dn[FRAME-1] && dn_n == 1,
                  $sformatf("done at last=%b total=%0d want 1/1", cap_dn[FRAME-1], dn_n));
        end
        exp_cnt = 16'd1;
        check_count("count after first frame");

        // Table vectors; inputs scrambled every cycle once the frame starts
        foreach (vecs[i]) begin
            int k;
            logic [15:0] got;
            run_frame(vecs[i].cfg, FRAME, 0, 1'b1);
            compare_frame($sformatf("vector %0d frame", i), 0, vecs[i].cfg);
            k = (vecs[i].y + VS + VB) * LT + 2 * vecs[i].x;
            got = {cap_d[k], cap_d[k+1]};
            check($sformatf("vector %0d pixel", i), cap_hr[k] && cap_hr[k+1] && got === vecs[i].exp,
                  $sformatf("y=%0d x=%0d got %h want %h", vecs[i].y, vecs[i].x, got, vecs[i].exp));
            exp_cnt++;
        end
        check_count("count after vectors");

        // Random configurations against the frame model
        for (int r = 0; r < 12; r++) begin
            c = rand_cfg();
            run_frame(c, FRAME, 0, 1'b1);
            compare_frame($sformatf("random frame %0d", r), 0, c);
            exp_cnt++;
        end

        // enable dropped at cycle 50: frame completes, then idle
        c = rand_cfg();
        run_frame(c, FRAME, 50, 1'b0);
        compare_frame("enable drop frame", 0, c);
        exp_cnt++;
        check_count("count after drop");
        expect_idle("idle after drop", 30);

        // enable held: second frame follows with no gap
        c = rand_cfg();
        run_frame(c, 2 * FRAME, FRAME + 5, 1'b0);
        compare_frame("back-to-back frame 1", 0, c);
        compare_frame("back-to-back frame 2", FRAME, c);
        exp_cnt += 16'd2;
        check_count("count after back-to-back");

        // frame_count wrap
        force dut.frame_cnt_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        check_count("count preload");
        c = rand_cfg();
        run_frame(c, FRAME, 0, 1'b0);
        compare_frame("wrap frame", 0, c);
        exp_cnt = 16'h0000;
        check_count("count wrap");

        // Async reset in the middle of an href pulse
        c = mkcfg(1, 16'h5A3C, 0, 0, 0, 0, 0, 0);
        run_frame(c, (VS + VB) * LT + 6, 0, 1'b0);
        check("mid-href before reset", cam.camera_href === 1'b1, $sformatf("href %b want 1", cam.camera_href));
        #2 reset = 1'b0;
        #1;
        check("async reset outputs",
              cam.camera_vsync === 1'b0 && cam.camera_href === 1'b0 && cam.camera_data === 8'h00 &&
              cam.frame_done === 1'b0 && cam.frame_count === 16'h0,
              $sformatf("vs/href/data/done/count %b/%b/%h/%b/%h want 0/0/00/0/0000",
                        cam.camera_vsync, cam.camera_href, cam.camera_data, cam.frame_done, cam.frame_count));
        @(negedge clk);
        reset = 1'b1;
        expect_idle("idle after reset", 3);
        c = rand_cfg();
        run_frame(c, FRAME, 0, 1'b1);
        compare_frame("frame after reset", 0, c);
        exp_cnt = 16'd1;
        check_count("count after reset frame");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
